// File: rtl/load_store_queue_pkg.sv
// Shared configuration for the load/store queue: default widths, funct3
// encodings, the IO window and load/store type codes.
package load_store_queue_pkg;

  localparam int DEPTH_W_DEF = 3;
  localparam int ROB_W_DEF   = 4;

  // Memory access size/sign encodings carried in funct3.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // IO space starts at 0x30000; bits [17:16] == 2'b11 select it.
  localparam logic [31:0] IO_BASE = 32'h0003_0000;

  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_STORE = 1'b1
  } op_e;

  function automatic logic [31:0] calc_addr(input logic [31:0] base, input logic [31:0] off);
    return base + off;
  endfunction

  function automatic logic is_io(input logic [31:0] addr);
    return addr[17:16] == IO_BASE[17:16];
  endfunction

  function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) begin
      return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    end else begin
      return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
             (f3 == F3_LBU) || (f3 == F3_LHU);
    end
  endfunction

endpackage

// File: rtl/load_store_queue_cdb_match.sv
// Matches one RoB id against all snooped broadcast buses; lowest bus wins.
module lsq_cdb_match #(
  parameter int ROB_W   = 4,
  parameter int NUM_CDB = 2
) (
  input  logic [ROB_W-1:0]         id,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0] cdb_rob_id,
  input  logic [NUM_CDB*32-1:0]    cdb_value,
  output logic                     hit,
  output logic [31:0]              value
);

  // Scan from the highest bus down so the lowest matching bus overrides.
  always_comb begin
    hit   = 1'b0;
    value = 32'h0;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      hit   = hit | (cdb_valid[k] && (cdb_rob_id[k*ROB_W +: ROB_W] == id));
      value = (cdb_valid[k] && (cdb_rob_id[k*ROB_W +: ROB_W] == id)) ?
              cdb_value[k*32 +: 32] : value;
    end
  end

endmodule

// File: rtl/load_store_queue_checker.sv
// Protocol checks for the load/store queue: no duplicate ids across buses,
// no accept/response collision, only legal funct3 codes issued.
module lsq_checker
  import load_store_queue_pkg::*;
#(
  parameter int ROB_W   = 4,
  parameter int NUM_CDB = 2
) (
  input logic                     clk,
  input logic                     rst,
  input logic                     flush,
  input logic [NUM_CDB-1:0]       cdb_valid,
  input logic [NUM_CDB*ROB_W-1:0] cdb_rob_id,
  input logic                     mem_req_valid,
  input logic                     mem_req_ready,
  input logic                     mem_resp_valid,
  input logic                     issue_valid,
  input logic                     issue_is_store,
  input logic [2:0]               issue_funct3
);

  logic dup_s;

  // Detect two valid buses carrying the same RoB id.
  always_comb begin
    dup_s = 1'b0;
    for (int j = 0; j < NUM_CDB; j++) begin
      for (int k = j + 1; k < NUM_CDB; k++) begin
        dup_s = dup_s | (cdb_valid[j] && cdb_valid[k] &&
                         (cdb_rob_id[j*ROB_W +: ROB_W] == cdb_rob_id[k*ROB_W +: ROB_W]));
      end
    end
  end

  a_no_dup_cdb: assert property (@(posedge clk) disable iff (rst || flush) !dup_s);
  a_no_req_resp_same: assert property (@(posedge clk) disable iff (rst || flush)
    !(mem_req_valid && mem_req_ready && mem_resp_valid));
  a_legal_funct3: assert property (@(posedge clk) disable iff (rst || flush)
    issue_valid |-> funct3_legal(issue_is_store, issue_funct3));

endmodule

// File: rtl/load_store_queue.sv
// In-order load/store queue with CDB snooping, program-order dispatch and a
// one-entry pending-response tracker. Optional macro LSQ_MMIO_ORDER_EN makes
// loads to IO space wait for RoB head like stores.
module load_store_queue
  import load_store_queue_pkg::*;
#(
  parameter int DEPTH_W      = DEPTH_W_DEF,
  parameter int ROB_W        = ROB_W_DEF,
  parameter int NUM_CDB      = 2,
  parameter int AFULL_MARGIN = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     flush,
  output logic                     full,
  output logic                     afull,
  output logic [DEPTH_W:0]         count,
  input  logic                     issue_valid,
  input  logic                     issue_is_store,
  input  logic [2:0]               issue_funct3,
  input  logic [31:0]              issue_imm,
  input  logic [31:0]              issue_v1,
  input  logic [31:0]              issue_v2,
  input  logic                     issue_q1_busy,
  input  logic                     issue_q2_busy,
  input  logic [ROB_W-1:0]         issue_q1,
  input  logic [ROB_W-1:0]         issue_q2,
  input  logic [ROB_W-1:0]         issue_rob_id,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0] cdb_rob_id,
  input  logic [NUM_CDB*32-1:0]    cdb_value,
  input  logic [ROB_W-1:0]         rob_head_id,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_we,
  output logic [2:0]               mem_req_funct3,
  output logic [31:0]              mem_req_addr,
  output logic [31:0]              mem_req_wdata,
  input  logic                     mem_resp_valid,
  input  logic [31:0]              mem_resp_rdata,
  output logic                     res_valid,
  output logic [ROB_W-1:0]         res_rob_id,
  output logic [31:0]              res_value
);

  localparam int DEPTH = 2 ** DEPTH_W;
  localparam logic [DEPTH_W:0] DEPTH_C = (DEPTH_W + 1)'(DEPTH);
  localparam logic [DEPTH_W:0] ONE_C   = (DEPTH_W + 1)'(1);

  typedef struct packed {
    logic             valid;
    op_e              op;
    logic [2:0]       funct3;
    logic [31:0]      imm;
    logic [31:0]      v1;
    logic [31:0]      v2;
    logic             q1_busy;
    logic             q2_busy;
    logic [ROB_W-1:0] q1;
    logic [ROB_W-1:0] q2;
    logic [ROB_W-1:0] rob_id;
  } entry_t;

  entry_t             entries_r [DEPTH];
  logic [DEPTH_W-1:0] head_r, tail_r;
  logic [DEPTH_W:0]   count_r;
  logic               pending_r, pending_we_r;
  logic [ROB_W-1:0]   pending_rob_id_r;
  logic               req_valid_r, req_we_r;
  logic [2:0]         req_funct3_r;
  logic [31:0]        req_addr_r, req_wdata_r;

  logic [DEPTH-1:0] hit1_s, hit2_s;
  logic [31:0]      val1_s [DEPTH];
  logic [31:0]      val2_s [DEPTH];
  logic             iss_hit1_s, iss_hit2_s;
  logic [31:0]      iss_val1_s, iss_val2_s;
  entry_t           new_entry_s, head_s;
  logic [31:0]      head_addr_s;
  logic             ordered_ok_s, enq_s, deq_s, full_s;

  for (genvar g = 0; g < DEPTH; g++) begin : g_snoop
    lsq_cdb_match #(.ROB_W(ROB_W), .NUM_CDB(NUM_CDB)) u_m1 (
      .id(entries_r[g].q1), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
      .cdb_value(cdb_value), .hit(hit1_s[g]), .value(val1_s[g]));
    lsq_cdb_match #(.ROB_W(ROB_W), .NUM_CDB(NUM_CDB)) u_m2 (
      .id(entries_r[g].q2), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
      .cdb_value(cdb_value), .hit(hit2_s[g]), .value(val2_s[g]));
  end

  lsq_cdb_match #(.ROB_W(ROB_W), .NUM_CDB(NUM_CDB)) u_iss1 (
    .id(issue_q1), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
    .cdb_value(cdb_value), .hit(iss_hit1_s), .value(iss_val1_s));
  lsq_cdb_match #(.ROB_W(ROB_W), .NUM_CDB(NUM_CDB)) u_iss2 (
    .id(issue_q2), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
    .cdb_value(cdb_value), .hit(iss_hit2_s), .value(iss_val2_s));

  lsq_checker #(.ROB_W(ROB_W), .NUM_CDB(NUM_CDB)) u_chk (
    .clk(clk), .rst(rst), .flush(flush), .cdb_valid(cdb_valid),
    .cdb_rob_id(cdb_rob_id), .mem_req_valid(req_valid_r),
    .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .issue_valid(issue_valid), .issue_is_store(issue_is_store),
    .issue_funct3(issue_funct3));

  assign head_s      = entries_r[head_r];
  assign head_addr_s = calc_addr(head_s.v1, head_s.imm);
  assign full_s      = (count_r == DEPTH_C);
  assign enq_s       = rdy && issue_valid && !full_s;
  assign deq_s       = rdy && head_s.valid && !head_s.q1_busy && !head_s.q2_busy &&
                       !pending_r && !req_valid_r && ordered_ok_s;

  // Build the entry being issued, folding in a same-cycle broadcast.
  always_comb begin
    new_entry_s         = '0;
    new_entry_s.valid   = 1'b1;
    new_entry_s.op      = op_e'(issue_is_store);
    new_entry_s.funct3  = issue_funct3;
    new_entry_s.imm     = issue_imm;
    new_entry_s.v1      = (issue_q1_busy && iss_hit1_s) ? iss_val1_s : issue_v1;
    new_entry_s.v2      = (issue_q2_busy && iss_hit2_s) ? iss_val2_s : issue_v2;
    new_entry_s.q1_busy = issue_q1_busy && !iss_hit1_s;
    new_entry_s.q2_busy = issue_q2_busy && !iss_hit2_s;
    new_entry_s.q1      = issue_q1;
    new_entry_s.q2      = issue_q2;
    new_entry_s.rob_id  = issue_rob_id;
  end

  // Decide whether the head op may leave speculatively or must wait for RoB head.
  always_comb begin
    ordered_ok_s = 1'b1;
    if (head_s.op == OP_STORE) begin
      ordered_ok_s = (rob_head_id == head_s.rob_id);
    end else begin
`ifdef LSQ_MMIO_ORDER_EN
      if (is_io(head_addr_s)) begin
        ordered_ok_s = (rob_head_id == head_s.rob_id);
      end else begin
        ordered_ok_s = 1'b1;
      end
`else
      ordered_ok_s = 1'b1;
`endif
    end
  end

  // Entry array: snoop busy operands, retire the head, write the tail.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) entries_r[i].valid <= 1'b0;
    end else if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entries_r[i].valid && entries_r[i].q1_busy && hit1_s[i]) begin
          entries_r[i].v1      <= val1_s[i];
          entries_r[i].q1_busy <= 1'b0;
        end
        if (entries_r[i].valid && entries_r[i].q2_busy && hit2_s[i]) begin
          entries_r[i].v2      <= val2_s[i];
          entries_r[i].q2_busy <= 1'b0;
        end
        if (deq_s && (head_r == DEPTH_W'(i))) entries_r[i].valid <= 1'b0;
        if (enq_s && (tail_r == DEPTH_W'(i))) entries_r[i] <= new_entry_s;
      end
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (rdy) begin
      if (enq_s) tail_r <= tail_r + DEPTH_W'(1);
      if (deq_s) head_r <= head_r + DEPTH_W'(1);
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + ONE_C;
        2'b01:   count_r <= count_r - ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

  // Memory request register and the single outstanding-op tracker.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      req_valid_r      <= 1'b0;
      req_we_r         <= 1'b0;
      req_funct3_r     <= 3'b000;
      req_addr_r       <= 32'h0;
      req_wdata_r      <= 32'h0;
      pending_r        <= 1'b0;
      pending_we_r     <= 1'b0;
      pending_rob_id_r <= '0;
    end else if (rdy) begin
      if (deq_s) begin
        req_valid_r      <= 1'b1;
        req_we_r         <= (head_s.op == OP_STORE);
        req_funct3_r     <= head_s.funct3;
        req_addr_r       <= head_addr_s;
        req_wdata_r      <= (head_s.op == OP_STORE) ? head_s.v2 : 32'h0;
        pending_we_r     <= (head_s.op == OP_STORE);
        pending_rob_id_r <= head_s.rob_id;
      end else if (req_valid_r && mem_req_ready) begin
        req_valid_r <= 1'b0;
      end
      if (req_valid_r && mem_req_ready) begin
        pending_r <= 1'b1;
      end else if (pending_r && mem_resp_valid) begin
        pending_r <= 1'b0;
      end
    end
  end

  assign full           = full_s;
  assign afull          = (int'(DEPTH_C - count_r) <= AFULL_MARGIN);
  assign count          = count_r;
  assign mem_req_valid  = req_valid_r;
  assign mem_req_we     = req_we_r;
  assign mem_req_funct3 = req_funct3_r;
  assign mem_req_addr   = req_addr_r;
  assign mem_req_wdata  = req_wdata_r;
  assign res_valid      = mem_resp_valid && pending_r;
  assign res_rob_id     = pending_rob_id_r;
  assign res_value      = pending_we_r ? 32'h0 : mem_resp_rdata;

endmodule

// File: tb/tb_load_store_queue.sv
// Directed self-checking bench for load_store_queue (default parameters).
module tb_load_store_queue;
  import load_store_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic        full, afull;
  logic [3:0]  count;
  logic        issue_valid, issue_is_store;
  logic [2:0]  issue_funct3;
  logic [31:0] issue_imm, issue_v1, issue_v2;
  logic        issue_q1_busy, issue_q2_busy;
  logic [3:0]  issue_q1, issue_q2, issue_rob_id;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_rob_id;
  logic [63:0] cdb_value;
  logic [3:0]  rob_head_id;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [2:0]  mem_req_funct3;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        res_valid;
  logic [3:0]  res_rob_id;
  logic [31:0] res_value;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_addr [8];

  always #5 clk = ~clk;

  load_store_queue dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .full(full), .afull(afull),
    .count(count), .issue_valid(issue_valid), .issue_is_store(issue_is_store),
    .issue_funct3(issue_funct3), .issue_imm(issue_imm), .issue_v1(issue_v1),
    .issue_v2(issue_v2), .issue_q1_busy(issue_q1_busy), .issue_q2_busy(issue_q2_busy),
    .issue_q1(issue_q1), .issue_q2(issue_q2), .issue_rob_id(issue_rob_id),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
    .rob_head_id(rob_head_id), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_funct3(mem_req_funct3), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata), .res_valid(res_valid),
    .res_rob_id(res_rob_id), .res_value(res_value));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input logic st, input logic [2:0] f3, input logic [31:0] imm,
                          input logic [31:0] v1, input logic [31:0] v2,
                          input logic q1b, input logic [3:0] q1, input logic [3:0] rob);
    issue_valid = 1'b1; issue_is_store = st; issue_funct3 = f3; issue_imm = imm;
    issue_v1 = v1; issue_v2 = v2; issue_q1_busy = q1b; issue_q1 = q1;
    issue_q2_busy = 1'b0; issue_q2 = 4'd0; issue_rob_id = rob;
    tick();
    issue_valid = 1'b0; issue_q1_busy = 1'b0;
  endtask

  // Accept the outstanding request, answer two cycles later, check the result.
  task automatic complete(input logic [3:0] rob, input logic [31:0] rdata, input logic [31:0] exp_val);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("hs_drop", {31'd0, mem_req_valid}, 32'd0);
    tick();
    mem_resp_valid = 1'b1; mem_resp_rdata = rdata;
    #1;
    chk("res_valid", {31'd0, res_valid}, 32'd1);
    chk("res_rob_id", {28'd0, res_rob_id}, {28'd0, rob});
    chk("res_value", res_value, exp_val);
    tick();
    mem_resp_valid = 1'b0; mem_resp_rdata = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic        got;
    logic [31:0] v1, imm;
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    issue_valid = 1'b0; issue_is_store = 1'b0; issue_funct3 = F3_LW; issue_imm = 32'h0;
    issue_v1 = 32'h0; issue_v2 = 32'h0; issue_q1_busy = 1'b0; issue_q2_busy = 1'b0;
    issue_q1 = 4'd0; issue_q2 = 4'd0; issue_rob_id = 4'd0;
    cdb_valid = 2'b00; cdb_rob_id = 8'h0; cdb_value = 64'h0; rob_head_id = 4'd15;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 32'h0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_afull", {31'd0, afull}, 32'd0);
    chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_req_addr", mem_req_addr, 32'd0);
    chk("rst_res_rob_id", {28'd0, res_rob_id}, 32'd0);

    // Eight ready loads, cache held off during issue; last one wraps the address.
    for (int k = 0; k < 8; k++) begin
      v1  = (k == 7) ? 32'hFFFF_FFF0 : 32'h1000 + k * 32'h100;
      imm = (k == 7) ? 32'h20 : k * 4;
      exp_addr[k] = v1 + imm;
      do_issue(1'b0, F3_LW, imm, v1, 32'h0, 1'b0, 4'd0, 4'(k));
    end
    chk("ld8_count", {28'd0, count}, 32'd7);
    for (int k = 0; k < 8; k++) begin
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
        if (mem_req_valid) got = 1'b1;
        else tick();
      end
      chk("ld8_req_seen", {31'd0, got}, 32'd1);
      chk("ld8_addr", mem_req_addr, exp_addr[k]);
      chk("ld8_we", {31'd0, mem_req_we}, 32'd0);
      chk("ld8_funct3", {29'd0, mem_req_funct3}, {29'd0, F3_LW});
      complete(4'(k), 32'hA000 + k, 32'hA000 + k);
    end
    chk("ld8_count_end", {28'd0, count}, 32'd0);

    // Store waits for RoB head.
    rob_head_id = 4'd0;
    do_issue(1'b1, F3_SW, 32'h8, 32'h200, 32'hDEAD_BEEF, 1'b0, 4'd0, 4'd3);
    tick();
    chk("st_wait1", {31'd0, mem_req_valid}, 32'd0);
    tick();
    chk("st_wait2", {31'd0, mem_req_valid}, 32'd0);
    rob_head_id = 4'd3;
    tick();
    chk("st_req_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("st_we", {31'd0, mem_req_we}, 32'd1);
    chk("st_addr", mem_req_addr, 32'h208);
    chk("st_wdata", mem_req_wdata, 32'hDEAD_BEEF);
    complete(4'd3, 32'h5555, 32'h0);
    rob_head_id = 4'd0;

    // Issue-cycle wake-up from CDB0.
    cdb_valid = 2'b01; cdb_rob_id = {4'd0, 4'd5}; cdb_value = {32'h0, 32'h1000};
    do_issue(1'b0, F3_LBU, 32'h10, 32'hBAD, 32'h0, 1'b1, 4'd5, 4'd6);
    cdb_valid = 2'b00; cdb_rob_id = 8'h0; cdb_value = 64'h0;
    chk("byp_count", {28'd0, count}, 32'd1);
    tick();
    chk("byp_req_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("byp_addr", mem_req_addr, 32'h1010);
    chk("byp_funct3", {29'd0, mem_req_funct3}, {29'd0, F3_LBU});
    complete(4'd6, 32'hFF, 32'hFF);

    // Waiting entry captures a later broadcast on CDB1.
    do_issue(1'b0, F3_LW, 32'h8, 32'h0, 32'h0, 1'b1, 4'd9, 4'd7);
    tick();
    chk("snp_wait", {31'd0, mem_req_valid}, 32'd0);
    cdb_valid = 2'b10; cdb_rob_id = {4'd9, 4'd0}; cdb_value = {32'h2000, 32'h0};
    tick();
    cdb_valid = 2'b00; cdb_rob_id = 8'h0; cdb_value = 64'h0;
    tick();
    chk("snp_req_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("snp_addr", mem_req_addr, 32'h2008);
    complete(4'd7, 32'h77, 32'h77);

    // IO-space load with RoB head elsewhere.
    rob_head_id = 4'd5;
    do_issue(1'b0, F3_LW, 32'h0, 32'h0003_0000, 32'h0, 1'b0, 4'd0, 4'd2);
    tick();
`ifdef LSQ_MMIO_ORDER_EN
    chk("io_stall1", {31'd0, mem_req_valid}, 32'd0);
    tick();
    chk("io_stall2", {31'd0, mem_req_valid}, 32'd0);
    rob_head_id = 4'd2;
    tick();
`endif
    chk("io_req_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("io_addr", mem_req_addr, 32'h0003_0000);
    complete(4'd2, 32'h1234, 32'h1234);
    rob_head_id = 4'd0;

    // Fill with stores that cannot leave yet; pointers wrap past the end.
    for (int k = 0; k < 8; k++) begin
      do_issue(1'b1, F3_SW, 32'h4, 32'h400 + k * 16, 32'(k), 1'b0, 4'd0, 4'(8 + k));
      chk("fill_count", {28'd0, count}, 32'(k + 1));
      chk("fill_full", {31'd0, full}, (k == 7) ? 32'd1 : 32'd0);
      chk("fill_afull", {31'd0, afull}, (k >= 6) ? 32'd1 : 32'd0);
    end
    do_issue(1'b1, F3_SW, 32'h0, 32'h800, 32'h0, 1'b0, 4'd0, 4'd1);
    chk("full_ignore_count", {28'd0, count}, 32'd8);
    chk("full_ignore_full", {31'd0, full}, 32'd1);
    rob_head_id = 4'd8;
    tick();
    chk("deq_count", {28'd0, count}, 32'd7);
    chk("deq_addr", mem_req_addr, 32'h404);
    chk("deq_wdata", mem_req_wdata, 32'd0);
    complete(4'd8, 32'h0, 32'h0);
    rob_head_id = 4'd9;
    do_issue(1'b1, F3_SW, 32'h0, 32'h900, 32'h0, 1'b0, 4'd0, 4'd0);
    chk("enqdeq_count", {28'd0, count}, 32'd7);
    chk("enqdeq_req_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("enqdeq_addr", mem_req_addr, 32'h414);
    chk("enqdeq_wdata", mem_req_wdata, 32'd1);
    complete(4'd9, 32'h0, 32'h0);

    // Flush with a request on the bus.
    rob_head_id = 4'd10;
    tick();
    chk("fla_req_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("fla_addr", mem_req_addr, 32'h424);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fla_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("fla_we", {31'd0, mem_req_we}, 32'd0);
    chk("fla_funct3", {29'd0, mem_req_funct3}, 32'd0);
    chk("fla_addr0", mem_req_addr, 32'd0);
    chk("fla_wdata", mem_req_wdata, 32'd0);
    chk("fla_count", {28'd0, count}, 32'd0);
    chk("fla_full", {31'd0, full}, 32'd0);
    chk("fla_res_rob_id", {28'd0, res_rob_id}, 32'd0);

    // Flush with a response pending; the late response is dropped.
    rob_head_id = 4'd0;
    do_issue(1'b0, F3_LW, 32'h0, 32'h300, 32'h0, 1'b0, 4'd0, 4'd4);
    tick();
    chk("flb_req_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("flb_addr", mem_req_addr, 32'h300);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hCAFE;
    #1;
    chk("flb_res_valid", {31'd0, res_valid}, 32'd0);
    tick();
    mem_resp_valid = 1'b0;
    chk("flb_count", {28'd0, count}, 32'd0);
    chk("flb_req_valid0", {31'd0, mem_req_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
